// File: rtl/voice_allocator.sv
// rtl/voice_allocator.sv - note-event voice scheduler and host/event command bus arbiter
module voice_allocator #(
    parameter int NUM_VOICES = 8
) (
    input  logic        clk37,
    input  logic        rst,
    input  logic [31:0] host_data,
    input  logic        host_valid,
    output logic        host_ready,
    input  logic        ev_valid,
    output logic        ev_ready,
    input  logic        ev_on,
    input  logic [6:0]  ev_note,
    input  logic [31:0] ev_freq,
    input  logic [17:0] op_shift,
    output logic [31:0] cmd_data,
    output logic        cmd_data_valid,
    output logic [7:0]  active_mask
);
    typedef enum logic [2:0] {
        IDLE, HOST_FWD, LOOKUP, STEAL_TOG, FREQ_HDR, FREQ_WORDS, ON_TOG, OFF_TOG
    } state_t;

    localparam logic [7:0] VMASK     = 8'((16'd1 << NUM_VOICES) - 16'd1);
    localparam logic [2:0] LAST_V    = 3'(NUM_VOICES - 1);
    localparam logic [7:0] CMD_SET   = 8'd1;
    localparam logic [7:0] CMD_TOG   = 8'd2;
    localparam logic [7:0] CMD_FREQ  = 8'd3;
    localparam logic       PRIO_HOST = 1'b0;
    localparam logic       PRIO_EV   = 1'b1;

    state_t      state_q, state_d;
    logic [31:0] cmd_data_q, cmd_data_d;
    logic        cmd_valid_q, cmd_valid_d;
    logic [7:0]  mask_q, mask_d;
    logic [7:0]  nvalid_q, nvalid_d;
    logic [6:0]  note_q [8];
    logic [6:0]  note_d [8];
    logic [2:0]  steal_ptr_q, steal_ptr_d;
    logic        prio_q, prio_d;
    logic [5:0]  host_cnt_q, host_cnt_d;
    logic [2:0]  word_cnt_q, word_cnt_d;
    logic [2:0]  voice_q, voice_d;
    logic        tog_after_q, tog_after_d;
    logic        ev_on_q, ev_on_d;
    logic [6:0]  ev_note_q, ev_note_d;
    logic [31:0] ev_freq_q, ev_freq_d;
    logic [17:0] op_shift_q, op_shift_d;

    logic        match_hit, free_hit;
    logic [2:0]  match_v, free_v;
    state_t      ws;
    logic [2:0]  wv;
    logic [7:0]  vbit;
    logic [17:0] sh_all;
    logic [2:0]  sh;

    function automatic logic [5:0] host_len(input logic [7:0] cmd);
        case (cmd)
            CMD_SET:  return 6'd56;
            CMD_FREQ: return 6'd6;
            default:  return 6'd0;
        endcase
    endfunction

    // Descending scan so the lowest-numbered idle voice wins.
    always_comb begin
        match_hit = 1'b0;
        match_v   = '0;
        free_hit  = 1'b0;
        free_v    = '0;
        for (int i = NUM_VOICES - 1; i >= 0; i--) begin
            if (nvalid_q[i] && note_q[i] == ev_note_q) begin
                match_hit = 1'b1;
                match_v   = 3'(i);
            end
            if (!nvalid_q[i]) begin
                free_hit = 1'b1;
                free_v   = 3'(i);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        cmd_data_d  = cmd_data_q;
        cmd_valid_d = 1'b0;
        mask_d      = mask_q;
        nvalid_d    = nvalid_q;
        note_d      = note_q;
        steal_ptr_d = steal_ptr_q;
        prio_d      = prio_q;
        host_cnt_d  = host_cnt_q;
        word_cnt_d  = word_cnt_q;
        voice_d     = voice_q;
        tog_after_d = tog_after_q;
        ev_on_d     = ev_on_q;
        ev_note_d   = ev_note_q;
        ev_freq_d   = ev_freq_q;
        op_shift_d  = op_shift_q;
        host_ready  = 1'b0;
        ev_ready    = 1'b0;
        ws          = state_q;
        wv          = voice_q;

        case (state_q)
            IDLE: begin
                host_ready = !ev_valid || prio_q == PRIO_HOST;
                ev_ready   = !host_valid || prio_q == PRIO_EV;
                if (host_valid && host_ready) begin
                    cmd_data_d  = host_data;
                    cmd_valid_d = 1'b1;
                    prio_d      = PRIO_EV;
                    host_cnt_d  = host_len(host_data[31:24]);
                    if (host_len(host_data[31:24]) != 6'd0) begin
                        state_d = HOST_FWD;
                    end
                    if (host_data[31:24] == CMD_TOG) begin
                        mask_d   = host_data[23:16] & VMASK;
                        nvalid_d = nvalid_q & mask_d;
                    end
                end else if (ev_valid && ev_ready) begin
                    prio_d     = PRIO_HOST;
                    ev_on_d    = ev_on;
                    ev_note_d  = ev_note;
                    ev_freq_d  = ev_freq;
                    op_shift_d = op_shift;
                    state_d    = LOOKUP;
                end
            end
            HOST_FWD: begin
                host_ready = 1'b1;
                if (host_valid) begin
                    cmd_data_d  = host_data;
                    cmd_valid_d = 1'b1;
                    host_cnt_d  = host_cnt_q - 6'd1;
                    if (host_cnt_q == 6'd1) begin
                        state_d = IDLE;
                    end
                end
            end
            default: ;
        endcase

        // LOOKUP resolves the voice and emits the first word itself, keeping latency at two cycles.
        if (state_q == LOOKUP) begin
            if (!ev_on_q) begin
                ws = match_hit ? OFF_TOG : IDLE;
                wv = match_v;
                if (match_hit) begin
                    nvalid_d[match_v] = 1'b0;
                end
            end else if (match_hit) begin
                ws          = FREQ_HDR;
                wv          = match_v;
                tog_after_d = 1'b0;
            end else if (free_hit) begin
                ws               = FREQ_HDR;
                wv               = free_v;
                tog_after_d      = 1'b1;
                note_d[free_v]   = ev_note_q;
                nvalid_d[free_v] = 1'b1;
            end else begin
                ws                    = STEAL_TOG;
                wv                    = steal_ptr_q;
                tog_after_d           = 1'b1;
                note_d[steal_ptr_q]   = ev_note_q;
                nvalid_d[steal_ptr_q] = 1'b1;
                steal_ptr_d           = (steal_ptr_q == LAST_V) ? 3'd0 : steal_ptr_q + 3'd1;
            end
            voice_d = wv;
        end

        vbit   = 8'd1 << wv;
        sh_all = op_shift_q >> (5'd3 * {2'b00, word_cnt_q});
        sh     = sh_all[2:0];

        if (state_q != IDLE && state_q != HOST_FWD) begin
            state_d = IDLE;
            case (ws)
                STEAL_TOG, OFF_TOG: begin
                    mask_d      = mask_q & ~vbit;
                    cmd_data_d  = {CMD_TOG, mask_d, 16'h0000};
                    cmd_valid_d = 1'b1;
                    state_d     = (ws == STEAL_TOG) ? FREQ_HDR : IDLE;
                end
                FREQ_HDR: begin
                    cmd_data_d  = {CMD_FREQ, vbit, 16'h0000};
                    cmd_valid_d = 1'b1;
                    word_cnt_d  = 3'd0;
                    state_d     = FREQ_WORDS;
                end
                FREQ_WORDS: begin
                    cmd_data_d  = ev_freq_q << sh;
                    cmd_valid_d = 1'b1;
                    if (word_cnt_q == 3'd5) begin
                        state_d = tog_after_q ? ON_TOG : IDLE;
                    end else begin
                        word_cnt_d = word_cnt_q + 3'd1;
                        state_d    = FREQ_WORDS;
                    end
                end
                ON_TOG: begin
                    mask_d      = (mask_q | vbit) & VMASK;
                    cmd_data_d  = {CMD_TOG, mask_d, 16'h0000};
                    cmd_valid_d = 1'b1;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk37 or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cmd_data_q  <= '0;
            cmd_valid_q <= 1'b0;
            mask_q      <= '0;
            nvalid_q    <= '0;
            for (int i = 0; i < 8; i++) begin
                note_q[i] <= '0;
            end
            steal_ptr_q <= '0;
            prio_q      <= PRIO_HOST;
            host_cnt_q  <= '0;
            word_cnt_q  <= '0;
            voice_q     <= '0;
            tog_after_q <= 1'b0;
            ev_on_q     <= 1'b0;
            ev_note_q   <= '0;
            ev_freq_q   <= '0;
            op_shift_q  <= '0;
        end else begin
            state_q     <= state_d;
            cmd_data_q  <= cmd_data_d;
            cmd_valid_q <= cmd_valid_d;
            mask_q      <= mask_d;
            nvalid_q    <= nvalid_d & VMASK;
            for (int i = 0; i < 8; i++) begin
                note_q[i] <= note_d[i];
            end
            steal_ptr_q <= steal_ptr_d;
            prio_q      <= prio_d;
            host_cnt_q  <= host_cnt_d;
            word_cnt_q  <= word_cnt_d;
            voice_q     <= voice_d;
            tog_after_q <= tog_after_d;
            ev_on_q     <= ev_on_d;
            ev_note_q   <= ev_note_d;
            ev_freq_q   <= ev_freq_d;
            op_shift_q  <= op_shift_d;
        end
    end

    assign cmd_data       = cmd_data_q;
    assign cmd_data_valid = cmd_valid_q;
    assign active_mask    = mask_q;
endmodule

// File: tb/tb_voice_allocator.sv
// tb/tb_voice_allocator.sv - directed bench for voice_allocator
module tb_voice_allocator;
    logic        clk37 = 1'b0;
    logic        rst;
    logic [31:0] host_data;
    logic        host_valid;
    logic        host_ready;
    logic        ev_valid;
    logic        ev_ready;
    logic        ev_on;
    logic [6:0]  ev_note;
    logic [31:0] ev_freq;
    logic [17:0] op_shift;
    logic [31:0] cmd_data;
    logic        cmd_data_valid;
    logic [7:0]  active_mask;

    int vecs = 0;
    int errs = 0;
    int cyc = 0;
    int acc_cyc = 0;
    logic [31:0] mq_data[$];
    int          mq_cyc[$];
    logic [31:0] expq[$];

    voice_allocator #(.NUM_VOICES(8)) dut (
        .clk37(clk37), .rst(rst),
        .host_data(host_data), .host_valid(host_valid), .host_ready(host_ready),
        .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_on(ev_on), .ev_note(ev_note),
        .ev_freq(ev_freq), .op_shift(op_shift),
        .cmd_data(cmd_data), .cmd_data_valid(cmd_data_valid), .active_mask(active_mask)
    );

    always #14 clk37 = ~clk37;

    always @(posedge clk37) cyc <= cyc + 1;

    always @(negedge clk37) begin
        if (cmd_data_valid) begin
            mq_data.push_back(cmd_data);
            mq_cyc.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk37);
    endtask

    task automatic send_ev(input logic on, input logic [6:0] note, input logic [31:0] freq,
                           input logic [17:0] sh);
        int n = 0;
        @(negedge clk37);
        ev_valid = 1'b1;
        ev_on    = on;
        ev_note  = note;
        ev_freq  = freq;
        op_shift = sh;
        #1;
        while (!ev_ready && n < 400) begin
            @(negedge clk37);
            #1;
            n++;
        end
        if (!ev_ready) begin
            chk("ev_accept_timeout", 32'd0, 32'd1);
        end else begin
            acc_cyc = cyc;
            @(posedge clk37);
        end
        #1 ev_valid = 1'b0;
    endtask

    task automatic send_host_word(input logic [31:0] w);
        int n = 0;
        @(negedge clk37);
        host_valid = 1'b1;
        host_data  = w;
        #1;
        while (!host_ready && n < 400) begin
            @(negedge clk37);
            #1;
            n++;
        end
        if (!host_ready) begin
            chk("host_accept_timeout", 32'd0, 32'd1);
        end else begin
            @(posedge clk37);
        end
        #1 host_valid = 1'b0;
    endtask

    task automatic push_freq6(input logic [31:0] f);
        for (int k = 0; k < 6; k++) expq.push_back(f);
    endtask

    task automatic check_words(input string tag, input int contig_n);
        int n;
        chk($sformatf("%s_count", tag), mq_data.size(), expq.size());
        n = (mq_data.size() < expq.size()) ? mq_data.size() : expq.size();
        for (int i = 0; i < n; i++) chk($sformatf("%s_w%0d", tag, i), mq_data[i], expq[i]);
        for (int i = 1; i < contig_n && i < n; i++)
            chk($sformatf("%s_gap%0d", tag, i), mq_cyc[i] - mq_cyc[i-1], 32'd1);
        mq_data.delete();
        mq_cyc.delete();
        expq.delete();
    endtask

    initial begin
        int n;
        logic [7:0] m;
        rst = 1'b1; host_valid = 1'b0; host_data = '0; ev_valid = 1'b0;
        ev_on = 1'b0; ev_note = '0; ev_freq = '0; op_shift = '0;
        idle(3);
        chk("rst_valid", cmd_data_valid, 32'd0);
        chk("rst_data", cmd_data, 32'd0);
        chk("rst_mask", active_mask, 32'd0);
        rst = 1'b0;

        // 1: first note-on lands on voice 0
        send_ev(1'b1, 7'd60, 32'h0012C579, 18'd0);
        idle(15);
        chk("t1_latency", (mq_cyc.size() > 0) ? mq_cyc[0] - acc_cyc : -1, 32'd2);
        expq.push_back(32'h03010000); push_freq6(32'h0012C579); expq.push_back(32'h02010000);
        check_words("t1", 8);
        chk("t1_mask", active_mask, 32'h01);

        // 2: fill voices 1..7, then two steals
        for (int nn = 61; nn <= 67; nn++) begin
            send_ev(1'b1, 7'(nn), 32'h1000 + nn, 18'd0);
            m = 8'((16'd1 << (nn - 59)) - 16'd1);
            expq.push_back({8'h03, 8'(16'd1 << (nn - 60)), 16'h0});
            push_freq6(32'h1000 + nn);
            expq.push_back({8'h02, m, 16'h0});
        end
        idle(15);
        check_words("t2_fill", 0);
        chk("t2_full_mask", active_mask, 32'hFF);
        send_ev(1'b1, 7'd68, 32'h00002000, 18'd0);
        idle(15);
        expq.push_back(32'h02FE0000); expq.push_back(32'h03010000);
        push_freq6(32'h00002000); expq.push_back(32'h02FF0000);
        check_words("t2_steal0", 9);
        send_ev(1'b1, 7'd69, 32'h00003000, 18'd0);
        idle(15);
        expq.push_back(32'h02FD0000); expq.push_back(32'h03020000);
        push_freq6(32'h00003000); expq.push_back(32'h02FF0000);
        check_words("t2_steal1", 9);

        // 3: note-off present / absent
        send_ev(1'b0, 7'd62, 32'h0, 18'd0);
        idle(8);
        expq.push_back(32'h02FB0000);
        check_words("t3_off62", 1);
        chk("t3_mask", active_mask, 32'hFB);
        send_ev(1'b0, 7'd99, 32'h0, 18'd0);
        idle(8);
        check_words("t3_off99", 0);

        // 4: SET_CMD packet with an event contending the whole time
        fork
            begin
                send_host_word(32'h0101ABCD);
                for (int i = 0; i < 56; i++) send_host_word(32'hA5000000 + i);
            end
            send_ev(1'b1, 7'd62, 32'h00001234, 18'd0);
        join
        idle(20);
        expq.push_back(32'h0101ABCD);
        for (int i = 0; i < 56; i++) expq.push_back(32'hA5000000 + i);
        expq.push_back(32'h03040000); push_freq6(32'h00001234); expq.push_back(32'h02FF0000);
        check_words("t4", 57);
        fork
            send_host_word(32'h020F0055);
            send_ev(1'b0, 7'd68, 32'h0, 18'd0);
        join
        idle(8);
        expq.push_back(32'h020F0055); expq.push_back(32'h020E0000);
        check_words("t4_prio", 0);
        chk("t4_mask", active_mask, 32'h0E);

        // 5: per-operator shifts
        send_ev(1'b1, 7'd70, 32'h80000001, {3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0});
        idle(15);
        expq.push_back(32'h03010000);
        expq.push_back(32'h80000001); expq.push_back(32'h00000002); expq.push_back(32'h00000004);
        expq.push_back(32'h00000008); expq.push_back(32'h00000010); expq.push_back(32'h00000020);
        expq.push_back(32'h020F0000);
        check_words("t5", 8);

        // host SET_FREQ_CMD with a gap mid-packet
        send_host_word(32'h03FF0000);
        for (int i = 0; i < 6; i++) begin
            send_host_word(32'hC0DE0000 + i);
            if (i == 2) begin
                chk("t7_ready_in_gap", host_ready, 32'd1);
                chk("t7_evready_in_gap", ev_ready, 32'd0);
                idle(2);
            end
        end
        idle(5);
        expq.push_back(32'h03FF0000);
        for (int i = 0; i < 6; i++) expq.push_back(32'hC0DE0000 + i);
        check_words("t7", 0);
        chk("t7_mask", active_mask, 32'h0F);

        // 6: reset during FREQ word 3
        send_ev(1'b1, 7'd71, 32'h00000777, 18'd0);
        n = 0;
        while (mq_data.size() < 4 && n < 60) begin
            @(negedge clk37);
            #1;
            n++;
        end
        chk("t6_reached_w3", (mq_data.size() >= 4) ? 32'd1 : 32'd0, 32'd1);
        chk("t6_hdr_voice4", (mq_data.size() > 0) ? mq_data[0] : 32'hX, 32'h03100000);
        #1 rst = 1'b1;
        #1;
        chk("t6_rst_valid", cmd_data_valid, 32'd0);
        chk("t6_rst_mask", active_mask, 32'd0);
        idle(2);
        rst = 1'b0;
        mq_data.delete();
        mq_cyc.delete();
        idle(3);
        check_words("t6_quiet", 0);
        send_ev(1'b1, 7'd72, 32'h00000100, 18'd0);
        idle(15);
        expq.push_back(32'h03010000); push_freq6(32'h00000100); expq.push_back(32'h02010000);
        check_words("t6_after", 8);
        chk("t6_mask", active_mask, 32'h01);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
